// File: rtl/i2c_seq_pkg.sv
// Shared state encoding and constants for the I2C burst sequencer.
package i2c_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_WAIT = 3'd1;
    localparam logic [2:0] ST_WR_XFC  = 3'd2;
    localparam logic [2:0] ST_RD_XFC  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_WAIT = ST_WR_WAIT,
        WR_XFC  = ST_WR_XFC,
        RD_XFC  = ST_RD_XFC,
        RD_WAIT = ST_RD_WAIT
    } state_t;

    // Bit replicated across the read byte returned for a timed-out read
    localparam logic RD_FILL = 1'b1;

endpackage

// File: rtl/i2c_edge_det.sv
// Rising-edge detector: one-cycle pulse when level goes high, history cleared on reset.
module i2c_edge_det (
    input  logic Clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= level;
    end

    assign pulse = level & ~prev_q;

endmodule

// File: rtl/i2c_burst_sequencer.sv
// I2C slave to register-bus burst sequencer with auto-increment address pointer.
// Optional bus_done timeout enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_burst_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int ADDR_MAX = 2047
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int TMO_CYC = 255
`endif
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              stop,
    input  logic              i2c_rw,
    input  logic [ADDR_W-1:0] i2c_addr_in,
    input  logic [DATA_W-1:0] i2c_data_in,
    input  logic              i2c_addr_ack,
    input  logic              i2c_data_ack,
    input  logic              i2c_rd_req,
    output logic [DATA_W-1:0] i2c_rd_data,
    output logic              i2c_rd_valid,
    output logic              bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_xfc,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_done,
    output logic              busy,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_d, start_ptr;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic              op_d, xfc_d, rvld_d, err_d;
    logic              addr_pls, data_pls, rdreq_pls;
    logic              start_bad, xfc_tmo, xfc_end;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (32'(p) == 32'(ADDR_MAX)) ? '0 : p + ADDR_W'(1);
    endfunction

    i2c_edge_det u_addr_edge (.Clock(Clock), .reset(reset), .level(i2c_addr_ack), .pulse(addr_pls));
    i2c_edge_det u_data_edge (.Clock(Clock), .reset(reset), .level(i2c_data_ack), .pulse(data_pls));
    i2c_edge_det u_rreq_edge (.Clock(Clock), .reset(reset), .level(i2c_rd_req),   .pulse(rdreq_pls));

    // Out-of-range start addresses restart the pointer at 0 and flag an error
    assign start_bad = 32'(i2c_addr_in) > 32'(ADDR_MAX);
    assign start_ptr = start_bad ? '0 : i2c_addr_in;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    assign xfc_tmo = bus_xfc && !bus_done && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset)                tmo_cnt_q <= '0;
        else if (bus_xfc && xfc_d) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        else                       tmo_cnt_q <= '0;
    end
`else
    assign xfc_tmo = 1'b0;
`endif

    assign xfc_end = bus_done | xfc_tmo;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = bus_op;
        addr_d  = bus_addr;
        wdata_d = bus_wdata;
        xfc_d   = bus_xfc;
        rdata_d = i2c_rd_data;
        rvld_d  = 1'b0;
        err_d   = err;
        if (stop) begin
            state_d = IDLE;
            xfc_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (addr_pls) begin
                    ptr_d = start_ptr;
                    op_d  = i2c_rw;
                    err_d = start_bad;
                    if (i2c_rw) begin
                        state_d = WR_WAIT;
                    end else begin
                        // Reads prefetch the first byte without waiting for a request
                        state_d = RD_XFC;
                        addr_d  = start_ptr;
                        xfc_d   = 1'b1;
                    end
                end
                WR_WAIT: if (data_pls) begin
                    wdata_d = i2c_data_in;
                    addr_d  = ptr_q;
                    op_d    = 1'b1;
                    xfc_d   = 1'b1;
                    state_d = WR_XFC;
                end
                WR_XFC: begin
                    if (data_pls) err_d = 1'b1;
                    if (xfc_end) begin
                        xfc_d   = 1'b0;
                        ptr_d   = ptr_inc(ptr_q);
                        state_d = WR_WAIT;
                        if (xfc_tmo) err_d = 1'b1;
                    end
                end
                RD_XFC: if (xfc_end) begin
                    rdata_d = bus_done ? bus_rdata : {DATA_W{RD_FILL}};
                    rvld_d  = 1'b1;
                    xfc_d   = 1'b0;
                    ptr_d   = ptr_inc(ptr_q);
                    state_d = RD_WAIT;
                    if (xfc_tmo) err_d = 1'b1;
                end
                RD_WAIT: if (rdreq_pls) begin
                    addr_d  = ptr_q;
                    op_d    = 1'b0;
                    xfc_d   = 1'b1;
                    state_d = RD_XFC;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            bus_op       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_xfc      <= 1'b0;
            i2c_rd_data  <= '0;
            i2c_rd_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            bus_op       <= op_d;
            bus_addr     <= addr_d;
            bus_wdata    <= wdata_d;
            bus_xfc      <= xfc_d;
            i2c_rd_data  <= rdata_d;
            i2c_rd_valid <= rvld_d;
            err          <= err_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Self-checking bench: table-driven bursts with a bus scoreboard, plus stop/overrun/reset/timeout sequences.
module tb_i2c_burst_sequencer;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 8;
    localparam int ADDR_MAX = 2047;

    logic              Clock;
    logic              reset;
    logic              stop;
    logic              i2c_rw;
    logic [ADDR_W-1:0] i2c_addr_in;
    logic [DATA_W-1:0] i2c_data_in;
    logic              i2c_addr_ack;
    logic              i2c_data_ack;
    logic              i2c_rd_req;
    logic [DATA_W-1:0] i2c_rd_data;
    logic              i2c_rd_valid;
    logic              bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_xfc;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_done;
    logic              busy;
    logic              err;

    logic resp_done, force_done, resp_en, xfc_prev;
    int   resp_delay, resp_cnt;
    int   n_chk, n_fail;

    assign bus_done = resp_done | force_done;

    i2c_burst_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_MAX(ADDR_MAX)
`ifdef I2C_SEQ_TIMEOUT_EN
        , .TMO_CYC(8)
`endif
    ) dut (
        .Clock(Clock), .reset(reset), .stop(stop), .i2c_rw(i2c_rw),
        .i2c_addr_in(i2c_addr_in), .i2c_data_in(i2c_data_in),
        .i2c_addr_ack(i2c_addr_ack), .i2c_data_ack(i2c_data_ack), .i2c_rd_req(i2c_rd_req),
        .i2c_rd_data(i2c_rd_data), .i2c_rd_valid(i2c_rd_valid),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_xfc(bus_xfc),
        .bus_rdata(bus_rdata), .bus_done(bus_done), .busy(busy), .err(err)
    );

    typedef struct {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_t;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] d0;
        int                n;
        logic              exp_err;
    } vec_t;

    bus_t              exp_bus[$];
    logic [DATA_W-1:0] exp_rd[$];
    vec_t              vecs[4];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench time limit");
    end

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        return (int'(a) == ADDR_MAX) ? '0 : a + 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // One clock: monitor the bus/read outputs against the scoreboard, then model the register file
    task automatic tick();
        bus_t e;
        logic [DATA_W-1:0] r;
        @(posedge Clock);
        #1;
        if (bus_xfc && !xfc_prev) begin
            if (exp_bus.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL bus_unexpected: xfc op %0d addr %h, required no transfer", bus_op, bus_addr);
            end else begin
                e = exp_bus.pop_front();
                chk("bus_op_addr", 32'({bus_op, bus_addr}), 32'({e.op, e.addr}));
                if (e.op) chk("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
            end
        end
        xfc_prev = bus_xfc;
        if (i2c_rd_valid) begin
            if (exp_rd.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid with %h, required none", i2c_rd_data);
            end else begin
                r = exp_rd.pop_front();
                chk("rd_data", 32'(i2c_rd_data), 32'(r));
            end
        end
        resp_done = 1'b0;
        if (bus_xfc && resp_en) begin
            resp_cnt++;
            if (resp_cnt >= resp_delay) begin
                resp_done = 1'b1;
                bus_rdata = bus_addr[7:0];
                resp_cnt  = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    endtask

    task automatic addr_edge(input logic rw, input logic [ADDR_W-1:0] a);
        i2c_rw = rw;
        i2c_addr_in = a;
        i2c_addr_ack = 1'b1;
        tick();
        i2c_addr_ack = 1'b0;
    endtask

    task automatic data_edge(input logic [DATA_W-1:0] d);
        i2c_data_in = d;
        i2c_data_ack = 1'b1;
        tick();
        i2c_data_ack = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_xfc_low(input string nm);
        for (int k = 0; k < 40; k++) begin
            if (!bus_xfc) return;
            tick();
        end
        chk(nm, 32'(bus_xfc), 32'd0);
    endtask

    task automatic wait_rdv(input string nm);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (i2c_rd_valid) return;
        end
        chk(nm, 32'(i2c_rd_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [ADDR_W-1:0] a;
        a = v.addr;
        for (int i = 0; i < v.n; i++) begin
            if (v.rw) begin
                exp_bus.push_back('{1'b1, a, 8'(v.d0 + 8'(i * 17))});
            end else begin
                exp_bus.push_back('{1'b0, a, 8'h00});
                exp_rd.push_back(a[7:0]);
            end
            a = nxt(a);
        end
        addr_edge(v.rw, v.addr);
        chk("busy_after_addr", 32'(busy), 32'd1);
        for (int i = 0; i < v.n; i++) begin
            if (v.rw) begin
                data_edge(8'(v.d0 + 8'(i * 17)));
                chk("wr_xfc_latency", 32'(bus_xfc), 32'd1);
                wait_xfc_low("wr_done_timeout");
            end else begin
                if (i > 0) begin
                    i2c_rd_req = 1'b1;
                    tick();
                    i2c_rd_req = 1'b0;
                end
                wait_rdv("rd_valid_timeout");
            end
        end
        chk("vec_err", 32'(err), 32'(v.exp_err));
        stop_pulse();
        chk("vec_busy_after_stop", 32'(busy), 32'd0);
        chk("vec_bus_queue", 32'(exp_bus.size()), 32'd0);
        chk("vec_rd_queue", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        vecs[0] = '{1'b1, 11'h010, 8'hA1, 3, 1'b0};
        vecs[1] = '{1'b0, 11'h7FE, 8'h00, 3, 1'b0};
        vecs[2] = '{1'b1, 11'h7FF, 8'h5A, 2, 1'b0};
        vecs[3] = '{1'b0, 11'h100, 8'h00, 1, 1'b0};

        reset = 1'b0; stop = 1'b0; i2c_rw = 1'b0; i2c_addr_in = '0; i2c_data_in = '0;
        i2c_addr_ack = 1'b0; i2c_data_ack = 1'b0; i2c_rd_req = 1'b0; bus_rdata = '0;
        resp_done = 1'b0; force_done = 1'b0; resp_en = 1'b1; resp_delay = 2; resp_cnt = 0;
        xfc_prev = 1'b0;

        tick();
        tick();
        chk("rst_outputs", 32'({bus_xfc, busy, err, i2c_rd_valid, bus_op}), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_rd_data", 32'(i2c_rd_data), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Stop while a write is in flight; a late bus_done must be ignored
        resp_en = 1'b0;
        exp_bus.push_back('{1'b1, 11'h200, 8'h33});
        addr_edge(1'b1, 11'h200);
        data_edge(8'h33);
        tick();
        chk("stop_pre_xfc", 32'(bus_xfc), 32'd1);
        stop_pulse();
        chk("stop_xfc", 32'(bus_xfc), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        chk("stop_late_done", 32'({bus_xfc, busy, i2c_rd_valid}), 32'd0);
        resp_en = 1'b1;

        // Overrun: second byte arrives while the first is still on the bus
        resp_delay = 4;
        exp_bus.push_back('{1'b1, 11'h300, 8'h44});
        addr_edge(1'b1, 11'h300);
        data_edge(8'h44);
        tick();
        data_edge(8'h55);
        chk("ovr_err", 32'(err), 32'd1);
        wait_xfc_low("ovr_done_timeout");
        repeat (3) tick();
        chk("ovr_single_write", 32'(exp_bus.size()), 32'd0);
        chk("ovr_err_sticky", 32'(err), 32'd1);
        stop_pulse();
        chk("ovr_err_after_stop", 32'(err), 32'd1);
        addr_edge(1'b1, 11'h000);
        chk("ovr_err_cleared", 32'(err), 32'd0);
        stop_pulse();
        resp_delay = 2;

        // Asynchronous reset in the middle of a read transfer
        resp_en = 1'b0;
        exp_bus.push_back('{1'b0, 11'h123, 8'h00});
        addr_edge(1'b0, 11'h123);
        tick();
        chk("arst_pre_xfc", 32'(bus_xfc), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ctrl", 32'({bus_xfc, busy, err, i2c_rd_valid, bus_op}), 32'd0);
        chk("arst_addr", 32'(bus_addr), 32'd0);
        chk("arst_data", 32'({i2c_rd_data, bus_wdata}), 32'd0);
        #1;
        reset = 1'b1;
        tick();
        resp_en = 1'b1;
        run_vec(vecs[3]);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Read whose bus_done never arrives: times out after 8 clocks with fill data
        resp_en = 1'b0;
        exp_bus.push_back('{1'b0, 11'h040, 8'h00});
        exp_rd.push_back(8'hFF);
        addr_edge(1'b0, 11'h040);
        repeat (7) tick();
        chk("tmo_hold", 32'(bus_xfc), 32'd1);
        tick();
        chk("tmo_xfc", 32'(bus_xfc), 32'd0);
        chk("tmo_valid", 32'(i2c_rd_valid), 32'd1);
        chk("tmo_data", 32'(i2c_rd_data), 32'hFF);
        chk("tmo_err", 32'(err), 32'd1);
        stop_pulse();
        resp_en = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
